// File: rtl/memory_arbiter_pkg.sv
// Shared types for the RAM arbiter: word type, RAM status and arbiter states.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    TURN = 2'd3
  } arbstate_t;

  // An ERROR response ends the access exactly like ACCESS does.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access,
// data first, with a starvation counter that eventually forces a fetch.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  ramstate_t   ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        memerr
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arbstate_t        state, state_nxt;
  logic [CNT_W-1:0] dcnt, dcnt_nxt;
  logic             dreq, rs_done, i_done, d_done;

  assign dreq    = dREN | dWEN;
  assign rs_done = ram_done(ramstate);
  // Completion also requires the port to still be asking; a dropped request is an abort.
  assign i_done  = (state == IGNT) & iREN & rs_done;
  assign d_done  = (state == DGNT) & dreq & rs_done;

  assign iwait = iREN & ~i_done;
  assign dwait = dreq & ~d_done;
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    unique case (state)
      IDLE: begin
        if (dreq && !(iREN && dcnt == CNT_MAX)) state_nxt = DGNT;
        else if (iREN)                          state_nxt = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (rs_done) state_nxt = TURN;
        end
      end
      DGNT: begin
        if (!dreq) begin
          state_nxt = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (rs_done) state_nxt = TURN;
        end
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only data completions while a fetch is waiting count toward starvation.
  always_comb begin
    dcnt_nxt = dcnt;
    if (i_done) begin
      dcnt_nxt = '0;
    end else if (d_done) begin
      if (!iREN)                dcnt_nxt = '0;
      else if (dcnt != CNT_MAX) dcnt_nxt = dcnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      dcnt   <= '0;
      memerr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_nxt;
      dcnt   <= dcnt_nxt;
      memerr <= memerr | ((i_done | d_done) & (ramstate == ERROR));
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), bubble after a completion.
  int m_owner  = 0;
  bit m_bubble = 1'b0;
  int m_cnt    = 0;
  bit m_err    = 1'b0;

  logic last_iwait, last_dwait;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic cycle();
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    bit          dreq, rsd, idone, ddone, is_err, req_i, req_d;
    #1;
    if (!nRST) begin
      m_owner = 0; m_bubble = 1'b0; m_cnt = 0; m_err = 1'b0;
    end
    dreq   = dREN | dWEN;
    rsd    = (ramstate == ACCESS) || (ramstate == ERROR);
    is_err = (ramstate == ERROR);
    req_i  = nRST && m_owner == 1 && iREN;
    req_d  = nRST && m_owner == 2 && dreq;
    idone  = req_i && rsd;
    ddone  = req_d && rsd;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (req_i) begin e_ren = 1'b1; e_addr = iaddr; end
    if (req_d) begin e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore; end
    e_iw = iREN && !idone;
    e_dw = dreq && !ddone;
    check("ramREN", 32'(ramREN), 32'(e_ren));
    check("ramWEN", 32'(ramWEN), 32'(e_wen));
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("iwait", 32'(iwait), 32'(e_iw));
    check("dwait", 32'(dwait), 32'(e_dw));
    check("memerr", 32'(memerr), 32'(m_err));
    if (idone) check("iload", iload, ramload);
    if (ddone) check("dload", dload, ramload);
    last_iwait = iwait;
    last_dwait = dwait;
    @(posedge CLK);
    if (nRST) begin
      if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (m_owner == 0) begin
        if (dreq && !(iREN && m_cnt == LIMIT)) m_owner = 2;
        else if (iREN)                         m_owner = 1;
      end else if (m_owner == 1) begin
        if (!iREN) m_owner = 0;
        else if (rsd) begin
          m_owner = 0; m_bubble = 1'b1; m_cnt = 0; m_err |= is_err;
        end
      end else begin
        if (!dreq) m_owner = 0;
        else if (rsd) begin
          m_owner = 0; m_bubble = 1'b1; m_err |= is_err;
          m_cnt = iREN ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  initial begin
    int dcount;
    bit i_served;
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    cycle();
    nRST = 1'b1;
    cycle();

    // Single fetch: two BUSY cycles then ACCESS.
    iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY; ramload = 32'h2402000A;
    cycle();
    cycle();
    cycle();
    ramstate = ACCESS;
    cycle();
    check("fetch_done", 32'(last_iwait), 32'd0);
    iREN = 1'b0; ramstate = FREE;
    cycle();
    cycle();

    // Conflict: data write wins, fetch follows after the bubble.
    iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD;
    ramstate = ACCESS; ramload = 32'h1234_5678;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (!last_dwait) dWEN = 1'b0;
      if (!last_iwait) iREN = 1'b0;
    end
    idle_inputs();
    cycle();

    // Starvation: fetch held, data requests back-to-back.
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h40; ramstate = ACCESS;
    dcount = 0; i_served = 1'b0;
    for (int k = 0; k < 60 && !i_served; k++) begin
      cycle();
      if (!last_dwait) dcount++;
      if (!last_iwait) i_served = 1'b1;
    end
    check("starve_served", 32'(i_served), 32'd1);
    check("starve_dcount", 32'(dcount), 32'(LIMIT));
    iREN = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    idle_inputs();
    cycle();

    // Abort a fetch while the RAM is busy.
    iREN = 1'b1; iaddr = 32'h400; ramstate = BUSY;
    cycle();
    cycle();
    iREN = 1'b0;
    cycle();
    check("abort_ren", 32'(ramREN), 32'd0);
    cycle();

    // Error response on a data read.
    dREN = 1'b1; daddr = 32'h500; ramstate = ERROR; ramload = 32'hBAD0_BAD0;
    cycle();
    cycle();
    check("err_dwait", 32'(last_dwait), 32'd0);
    dREN = 1'b0; ramstate = FREE;
    cycle();
    check("err_sticky", 32'(memerr), 32'd1);

    // Random traffic; requests persist until served or occasionally dropped.
    for (int n = 0; n < 2000; n++) begin
      if (!iREN || !last_iwait || $urandom_range(0, 19) == 0) begin
        iREN  = ($urandom_range(0, 2) != 0);
        iaddr = $urandom;
      end
      if (!(dREN || dWEN) || !last_dwait || $urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin dREN = 1'b0; dWEN = 1'b0; end
          1:       begin dREN = 1'b1; dWEN = 1'b0; end
          default: begin dREN = 1'b0; dWEN = 1'b1; end
        endcase
        daddr  = $urandom;
        dstore = $urandom;
      end
      case ($urandom_range(0, 9))
        0:             ramstate = FREE;
        1:             ramstate = (n > 1000) ? ERROR : BUSY;
        2, 3, 4, 5:    ramstate = BUSY;
        default:       ramstate = ACCESS;
      endcase
      ramload = $urandom;
      cycle();
    end

    // Reset asynchronously in the middle of a busy data grant.
    idle_inputs();
    cycle();
    cycle();
    dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
    cycle();
    cycle();
    nRST = 1'b0;
    #1;
    check("rst_ren", 32'(ramREN), 32'd0);
    check("rst_addr", ramaddr, 32'd0);
    check("rst_memerr", 32'(memerr), 32'd0);
    check("rst_dwait", 32'(dwait), 32'd1);
    cycle();
    nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
